fib_sched: RTL and testbench
============================

# fib_sched

Request scheduler for the Fibonacci datapath: shares one iterative Fibonacci stepping engine between NREQ requesters. Each requester asks for F(k); the block arbitrates round-robin, sequences the stepping, and returns F(k) with requester ID and an overflow flag over a valid/ready response channel. It sits between client logic and the Fibonacci generator resource, replacing free-running enable control with counted, per-request sequencing.

## Interface
- NREQ, 2, number of requesters (2..8)
- W, 16, result width
- IW, 6, index width (k up to 2^IW-1)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_idx  in  NREQ*IW  per-requester index k, requester i at bits [i*IW +: IW]
- req_ready  out  NREQ  one-hot accept, only to granted requester
- stall  in  1  freezes stepping while high
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  W  F(k) modulo 2^W
- rsp_id  out  $clog2(NREQ) (min 1)  requester index of result
- rsp_ovf  out  1  F(k) exceeded W bits
- busy  out  1  high in any state except IDLE

## Operation
- F(0)=0, F(1)=1. Engine holds a=F(i), b=F(i+1), step count cnt.
- FSM states: IDLE, RUN, DONE.
- IDLE: arbiter grants one valid requester; req_ready[g]=1 combinationally; on that edge load a=0, b=1, cnt=req_idx[g], id=g; go RUN. No request: stay.
- RUN, stall=0, cnt!=0: a<=b, b<=a+b (truncated to W), cnt<=cnt-1.
- RUN, stall=0, cnt==0: register rsp_data=a, rsp_ovf, rsp_id; go DONE.
- RUN, stall=1: hold all state, including cnt==0 case.
- DONE: rsp_valid=1, rsp_data/rsp_id/rsp_ovf stable until rsp_ready; on handshake go IDLE. Next grant no earlier than cycle after handshake.
- Round-robin: pointer = last granted; search starts at pointer+1 wrapping at NREQ. Reset: requester 0 highest priority. Pointer updates only on accepted grant.
- Requests arriving in RUN/DONE wait; requester must hold req_valid and req_idx stable until req_ready.
- Overflow tracking: ovf_a, ovf_b flags. Load clears both. Step: ovf_a<=ovf_b; ovf_b<=ovf_b | ovf_a | carry-out(a+b). rsp_ovf=ovf_a.

## Timing
- Reset (async assert, sync deassert upstream): state=IDLE, req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_ovf=0, busy=0, pointer=NREQ-1.
- Reset mid-RUN or mid-DONE: request and pending result discarded; no response issued.
- Latency: accept edge E0; rsp_valid rises after edge E0+k+1 with no stall; each stalled cycle adds one.
- Back-to-back: two queued requests, rsp_ready tied 1 -> second accept one cycle after first response handshake.
- k=0: result 0 one cycle after RUN entry; k at max 2^IW-1 handled, cnt never wraps.

## Configuration
- FIB_SCHED_OVF_EN defined: overflow flags implemented, rsp_ovf as above.
- Undefined: no overflow flags; rsp_ovf tied 0; rsp_data still F(k) mod 2^W.

## Structure
- Package fib_sched_pkg: state enum (IDLE, RUN, DONE), default W/IW/NREQ constants, id-width function.
- Sub-module fib_rr_arb: round-robin arbiter (req vector, advance strobe -> one-hot grant, encoded index, pointer register).
- Stepping engine, counter, FSM and response register in fib_sched.

## Test plan
- Reset then single request req0 k=10, rsp_ready=1 -> rsp_data=55, rsp_id=0, rsp_ovf=0, rsp_valid rises 11 cycles after accept.
- k=0 and k=1 -> rsp_data 0 and 1, latencies 1 and 2 cycles.
- W=16, k=24 -> 46368 ovf=0; k=25 -> 9489 ovf=1 (0 without FIB_SCHED_OVF_EN).
- Both requesters valid continuously, k=3 each -> grants alternate 0,1,0,1; rsp_id matches; rsp_data=2 each.
- k=5 with stall high 3 cycles mid-RUN, rsp_ready low 4 cycles in DONE -> rsp_data=5, latency 9, outputs stable while held.
- rst pulsed during RUN of k=20 -> outputs zero immediately, no response; subsequent k=7 request -> 13.

Source files
------------

// File: rtl/fib_sched_pkg.sv
// fib_sched_pkg: shared types and constants for the Fibonacci request scheduler.
//   state_t   - scheduler FSM states (IDLE, RUN, DONE)
//   DEF_*     - default requester count, result width and index width
//   id_width  - width of an encoded requester index (minimum 1 bit)
package fib_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int unsigned DEF_NREQ = 2;
    localparam int unsigned DEF_W    = 16;
    localparam int unsigned DEF_IW   = 6;

    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fib_rr_arb.sv
// fib_rr_arb: round-robin arbiter for the Fibonacci scheduler.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   req          - per-requester request vector
//   advance      - grant was accepted this cycle; pointer moves to it
//   grant        - one-hot grant (combinational)
//   grant_idx    - encoded index of the granted requester
//   grant_valid  - at least one requester is asking
// The pointer holds the last accepted requester; the search begins one past
// it. Reset value NREQ-1 gives requester 0 highest priority first.
module fib_rr_arb #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_valid
);

    logic [IDW-1:0] ptr;
    int unsigned    cand;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = 0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            cand = int'(ptr) + off;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!grant_valid && req[cand[IDW-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[IDW-1:0];
            end
        end
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= IDW'(NREQ - 1);
        end else if (advance && grant_valid) begin
            ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/fib_sched.sv
// fib_sched: shares one iterative Fibonacci stepping engine between NREQ
// requesters. Requests are granted round-robin; each computes F(k) by k
// steps of (a,b) <= (b,a+b) and returns the result over valid/ready.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   req_valid/req_idx   - per-requester request and index k (IW bits each)
//   req_ready           - one-hot accept to the granted requester (IDLE only)
//   stall               - freezes stepping and completion while high
//   rsp_valid/rsp_ready - response handshake
//   rsp_data            - F(k) mod 2^W
//   rsp_id              - requester index of the result
//   rsp_ovf             - F(k) did not fit in W bits
//   busy                - high outside IDLE
// Build option: define FIB_SCHED_OVF_EN to implement overflow tracking;
// otherwise rsp_ovf is tied low.
module fib_sched
    import fib_sched_pkg::*;
#(
    parameter  int unsigned NREQ = DEF_NREQ,
    parameter  int unsigned W    = DEF_W,
    parameter  int unsigned IW   = DEF_IW,
    localparam int unsigned IDW  = id_width(NREQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req_valid,
    input  logic [NREQ*IW-1:0] req_idx,
    output logic [NREQ-1:0]  req_ready,
    input  logic             stall,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_data,
    output logic [IDW-1:0]   rsp_id,
    output logic             rsp_ovf,
    output logic             busy
);

    state_t          state, next_state;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_valid;
    logic            accept;
    logic            step;
    logic            finish;

    logic [W-1:0]    a, b;
    logic [W-1:0]    sum;
    logic            carry;
    logic [IW-1:0]   cnt;
    logic [IW-1:0]   sel_idx;
    logic [IDW-1:0]  id_r;
    logic [W-1:0]    rsp_data_r;
    logic [IDW-1:0]  rsp_id_r;

    fib_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (req_valid),
        .advance     (accept),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign sel_idx      = req_idx[int'(grant_idx)*IW +: IW];
    assign {carry, sum} = {1'b0, a} + {1'b0, b};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (cnt != '0) begin
                        step = 1'b1;
                    end else begin
                        finish     = 1'b1;
                        next_state = DONE;
                    end
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Grant is only offered in IDLE, and is masked while reset is held so
    // requesters never see an accept the core will not take.
    assign req_ready = (state == IDLE && !rst) ? grant : '0;
    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign rsp_data  = rsp_data_r;
    assign rsp_id    = rsp_id_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a          <= '0;
            b          <= '0;
            cnt        <= '0;
            id_r       <= '0;
            rsp_data_r <= '0;
            rsp_id_r   <= '0;
        end else if (accept) begin
            a    <= '0;
            b    <= W'(1);
            cnt  <= sel_idx;
            id_r <= grant_idx;
        end else if (step) begin
            a   <= b;
            b   <= sum;
            cnt <= cnt - 1'b1;
        end else if (finish) begin
            rsp_data_r <= a;
            rsp_id_r   <= id_r;
        end
    end

`ifdef FIB_SCHED_OVF_EN
    // ovf_a/ovf_b mark that F(i)/F(i+1) no longer fit; once set they
    // propagate forward with the values they describe.
    logic ovf_a, ovf_b, rsp_ovf_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_a     <= 1'b0;
            ovf_b     <= 1'b0;
            rsp_ovf_r <= 1'b0;
        end else if (accept) begin
            ovf_a <= 1'b0;
            ovf_b <= 1'b0;
        end else if (step) begin
            ovf_a <= ovf_b;
            ovf_b <= ovf_b | ovf_a | carry;
        end else if (finish) begin
            rsp_ovf_r <= ovf_a;
        end
    end

    assign rsp_ovf = rsp_ovf_r;
`else
    logic unused_carry;
    assign unused_carry = carry;
    assign rsp_ovf      = 1'b0;
`endif

endmodule

// File: tb/tb_fib_sched.sv
module tb_fib_sched;

    localparam int unsigned NREQ = 2;
    localparam int unsigned W    = 16;
    localparam int unsigned IW   = 6;
    localparam int unsigned IDW  = 1;

`ifdef FIB_SCHED_OVF_EN
    localparam logic OVF25 = 1'b1;
`else
    localparam logic OVF25 = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*IW-1:0] req_idx;
    logic [NREQ-1:0]   req_ready;
    logic              stall;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_data;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_ovf;
    logic              busy;

    int checks = 0;
    int errors = 0;

    fib_sched #(
        .NREQ (NREQ),
        .W    (W),
        .IW   (IW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_idx   (req_idx),
        .req_ready (req_ready),
        .stall     (stall),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise a request, wait (bounded) for req_ready, then step past the accept edge.
    task automatic accept(input int r, input int k, output bit ok);
        ok = 1'b0;
        req_valid[r] = 1'b1;
        req_idx[r*IW +: IW] = IW'(k);
        #1;
        for (int n = 0; n < 100; n++) begin
            if (req_ready[r]) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        req_valid[r] = 1'b0;
    endtask

    // Count cycles after the accept edge until rsp_valid is seen (bounded).
    task automatic wait_rsp(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int n = 0; n < 300; n++) begin
            tick();
            lat++;
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_idx   = '0;
        stall     = 1'b0;
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== 2'b00 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: req_ready=%b rsp_valid=%b busy=%b, want 00 0 0", req_ready, rsp_valid, busy);
        end
        checks++;
        if (rsp_data !== 16'd0 || rsp_id !== 1'b0 || rsp_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp: data=%0d id=%0d ovf=%b, want 0 0 0", rsp_data, rsp_id, rsp_ovf);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        bit ok;
        int lat;
        rsp_ready = 1'b1;
        accept(0, 10, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_accept: no req_ready, want accept"); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: busy=%b, want 1", busy); end
        wait_rsp(lat, ok);
        checks++;
        if (!ok || lat != 11) begin errors++; $display("FAIL single_lat: got=%0d ok=%0d, want 11", lat, ok); end
        checks++;
        if (rsp_data !== 16'd55 || rsp_id !== 1'b0 || rsp_ovf !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp: data=%0d id=%0d ovf=%b, want 55 0 0", rsp_data, rsp_id, rsp_ovf);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: rsp_valid=%b busy=%b, want 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_small_k();
        bit ok;
        int lat;
        rsp_ready = 1'b1;
        accept(0, 0, ok);
        wait_rsp(lat, ok);
        checks++;
        if (!ok || lat != 1 || rsp_data !== 16'd0) begin
            errors++;
            $display("FAIL k0: lat=%0d data=%0d ok=%0d, want lat 1 data 0", lat, rsp_data, ok);
        end
        tick();
        accept(1, 1, ok);
        wait_rsp(lat, ok);
        checks++;
        if (!ok || lat != 2 || rsp_data !== 16'd1 || rsp_id !== 1'b1) begin
            errors++;
            $display("FAIL k1: lat=%0d data=%0d id=%0d ok=%0d, want lat 2 data 1 id 1", lat, rsp_data, rsp_id, ok);
        end
        tick();
    endtask

    task automatic test_overflow();
        bit ok;
        int lat;
        rsp_ready = 1'b1;
        accept(0, 24, ok);
        wait_rsp(lat, ok);
        checks++;
        if (!ok || lat != 25 || rsp_data !== 16'd46368 || rsp_ovf !== 1'b0) begin
            errors++;
            $display("FAIL k24: lat=%0d data=%0d ovf=%b, want 25 46368 0", lat, rsp_data, rsp_ovf);
        end
        tick();
        accept(0, 25, ok);
        wait_rsp(lat, ok);
        checks++;
        if (!ok || rsp_data !== 16'd9489 || rsp_ovf !== OVF25) begin
            errors++;
            $display("FAIL k25: data=%0d ovf=%b ok=%0d, want 9489 %b", rsp_data, rsp_ovf, ok, OVF25);
        end
        tick();
    endtask

    task automatic test_round_robin();
        int  got;
        bit  prev;
        logic [NREQ-1:0] want_ready;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        req_idx   = {IW'(3), IW'(3)};
        req_valid = 2'b11;
        got  = 0;
        prev = 1'b0;
        want_ready = '0;
        for (int n = 0; n < 200 && got < 4; n++) begin
            tick();
            if (prev) begin
                checks++;
                if (req_ready !== want_ready) begin
                    errors++;
                    $display("FAIL back_to_back: req_ready=%b after handshake %0d, want %b", req_ready, got, want_ready);
                end
            end
            prev = 1'b0;
            if (rsp_valid) begin
                checks++;
                if (rsp_id !== IDW'(got % 2) || rsp_data !== 16'd2) begin
                    errors++;
                    $display("FAIL rr_rsp%0d: id=%0d data=%0d, want id %0d data 2", got, rsp_id, rsp_data, got % 2);
                end
                got++;
                if (got < 4) begin
                    prev = 1'b1;
                    want_ready = (got % 2 == 1) ? 2'b10 : 2'b01;
                end else begin
                    req_valid = '0;
                end
            end
        end
        checks++;
        if (got != 4) begin errors++; $display("FAIL rr_count: responses=%0d, want 4", got); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_stall_hold();
        bit ok;
        int lat;
        int l2;
        rsp_ready = 1'b0;
        stall     = 1'b0;
        accept(1, 5, ok);
        lat = 0;
        tick(); lat++;
        tick(); lat++;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); lat++;
        end
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_run: rsp_valid=%b busy=%b, want 0 1", rsp_valid, busy);
        end
        stall = 1'b0;
        wait_rsp(l2, ok);
        lat += l2;
        checks++;
        if (!ok || lat != 9 || rsp_data !== 16'd5 || rsp_id !== 1'b1) begin
            errors++;
            $display("FAIL stall_rsp: lat=%0d data=%0d id=%0d, want 9 5 1", lat, rsp_data, rsp_id);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 16'd5 || rsp_id !== 1'b1) begin
                errors++;
                $display("FAIL hold%0d: valid=%b data=%0d id=%0d, want 1 5 1", i, rsp_valid, rsp_data, rsp_id);
            end
        end
        rsp_ready = 1'b1;
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL hold_release: rsp_valid=%b, want 0", rsp_valid); end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        int lat;
        int seen;
        rsp_ready = 1'b1;
        accept(0, 20, ok);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 16'd0 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset: busy=%b valid=%b data=%0d req_ready=%b, want 0 0 0 00", busy, rsp_valid, rsp_data, req_ready);
        end
        #2;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rsp_valid) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL discard: rsp_valid cycles=%0d, want 0", seen); end
        accept(0, 7, ok);
        wait_rsp(lat, ok);
        checks++;
        if (!ok || lat != 8 || rsp_data !== 16'd13 || rsp_id !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: lat=%0d data=%0d id=%0d, want 8 13 0", lat, rsp_data, rsp_id);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_small_k();
        test_overflow();
        test_round_robin();
        test_stall_hold();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
